imem_loader: RTL
================

# imem_loader

Program loader that writes the instruction memory read by the fetch stage. It accepts a byte stream over a valid/ready handshake: a word-count header, little-endian 32-bit instruction words, and an XOR checksum. It assembles each group of four bytes into a word and issues one registered write per word into instruction memory. It holds the core (`core_hold`) from load start until the image is verified, so fetch never executes a partially written program.

## Interface
- `DEPTH`, default 16: instruction memory depth in 32-bit words. Legal range is 1..255.
- `ADDR_W`, default 4: word address width. Must satisfy 2^ADDR_W >= DEPTH.
- `clk`  input  1  clock. All state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  one-cycle pulse that begins a load.
- `byte_valid`  input  1  `byte_data` is valid.
- `byte_data`  input  8  stream byte.
- `byte_ready`  output  1  loader can accept a byte.
- `mem_we`  output  1  instruction memory write enable, one-cycle pulse per word.
- `mem_addr`  output  ADDR_W  word index of the write.
- `mem_wdata`  output  32  assembled instruction word.
- `core_hold`  output  1  hold the fetch PC and core in reset.
- `done`  output  1  image loaded and checksum matched.
- `error`  output  1  bad count or checksum mismatch.

## Operation
- A byte is accepted only on a rising edge where `byte_valid && byte_ready`. Bytes presented while `byte_ready`=0 are ignored.
- States:
  - IDLE: `byte_ready`=0. `start` goes to COUNT.
  - COUNT: first accepted byte is N. If N==0 or N>DEPTH, go to ERROR. Otherwise latch N, clear word_idx, byte_idx and checksum, then go to DATA.
  - DATA: accepted byte k of a word goes to bits [8k+7:8k] (little-endian, k=0..3). Checksum is updated as checksum ^= byte. After the 4th byte of a word, word_idx increments; after the 4th byte of word N-1, go to CHECK.
  - CHECK: accepted byte == checksum goes to DONE; otherwise go to ERROR.
  - DONE: `done`=1, `core_hold`=0, `byte_ready`=0. `start` goes to COUNT.
  - ERROR: `error`=1, `core_hold`=1, `byte_ready`=0. `start` goes to COUNT.
- `byte_ready`=1 exactly in COUNT, DATA and CHECK.
- `core_hold` rises on the cycle after `start` is accepted and falls on entry to DONE.
- `start` in COUNT, DATA or CHECK is ignored; the load continues.
- `start` in DONE or ERROR clears `done`/`error` on the next edge.
- The header byte and checksum byte are not included in the checksum.
- Words already written before an ERROR are not rolled back.
- Internal counters: word_idx is ADDR_W+1 bits; byte_idx is 2 bits and wraps 3->0.
- N is compared as an 8-bit unsigned value.

## Timing
- Reset values: `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `core_hold`=0, `done`=0, `error`=0. State is IDLE and all counters and checksum are 0.
- Reset mid-load aborts immediately (asynchronous); no further `mem_we` is issued.
- `mem_we`, `mem_addr` and `mem_wdata` are registered:
  - The pulse occurs in the cycle after the edge that accepted the 4th byte of a word.
  - `mem_addr` = that word's index.
  - `mem_we` is high for exactly one cycle.
  - `mem_addr`/`mem_wdata` hold their last values afterwards.
- With `byte_valid` held high, one byte is accepted per cycle, so a full load takes 1+4N+1 accepted bytes.
- The final word's `mem_we` occurs in the same cycle the loader is in CHECK. That write completes no later than the edge where `done` rises.
- Gaps in `byte_valid` only stall the sequence; there is no timeout.
- `done`/`error` are level outputs. They rise on the edge that accepts the deciding byte, or on the edge that accepts the bad count byte.

## Test plan
- Reset: assert `reset` mid-cycle. All outputs go 0 immediately; `byte_valid` pulses while in IDLE cause no acceptance.
- Good load, DEPTH=16: `start`, then bytes 02,13,00,00,00,93,00,A0,00,20.
  - Expect `mem_we` @addr0 with 0x00000013.
  - Expect `mem_we` @addr1 with 0x00A00093.
  - `done`=1 and `core_hold` falls after the byte 20; `error`=0.
- Bad checksum: same stream with the last byte 21.
  - Both writes still occur.
  - `error`=1, `core_hold` stays 1, `done`=0.
- Bad count: count byte 00, and separately 11 (17 > DEPTH).
  - `error`=1 on the next edge with no `mem_we`.
  - A following `start` with a good stream clears `error` and ends in `done`=1.
- Backpressure and gaps: good stream with `byte_valid` dropped for 3 cycles between every byte.
  - Identical writes and result.
  - A `start` pulse mid-DATA is ignored.
- Reset mid-load: assert `reset` after 5 data bytes.
  - All outputs go 0 and no further `mem_we` is issued.
  - A fresh `start` with N=1, word 0xDEADBEEF (bytes 01,EF,BE,AD,DE,checksum 22) writes addr0 with 0xDEADBEEF and sets `done`=1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
// Ports: clk/reset, start, byte_valid/byte_data/byte_ready stream,
//   mem_we/mem_addr/mem_wdata write port, core_hold, done, error.
module imem_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    // Wide enough for both word_idx+1 and the 8-bit count.
    localparam int CW = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
    localparam logic [ADDR_W:0] WIDX_ONE = 1;

    logic [2:0]        state;
    logic [7:0]        n_cnt;
    logic [ADDR_W:0]   word_idx;
    logic [1:0]        byte_idx;
    logic [7:0]        checksum;
    logic [23:0]       word_buf;

    logic              accept;
    logic              count_ok;
    logic              last_word;
    logic [CW-1:0]     word_num;

    assign accept    = byte_valid && byte_ready;
    assign count_ok  = (byte_data != 8'd0)
                    && (int'(byte_data) <= DEPTH);
    assign word_num  = CW'(word_idx) + CW'(1);
    assign last_word = (word_num == CW'(n_cnt));

    // Status outputs are pure functions of the state.
    assign byte_ready = (state == S_COUNT)
                     || (state == S_DATA)
                     || (state == S_CHECK);
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERROR);
    assign core_hold  = (state != S_IDLE)
                     && (state != S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            n_cnt     <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            checksum  <= '0;
            word_buf  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) state <= S_COUNT;
                end
                S_COUNT: begin
                    if (accept) begin
                        if (count_ok) begin
                            n_cnt    <= byte_data;
                            word_idx <= '0;
                            byte_idx <= '0;
                            checksum <= '0;
                            state    <= S_DATA;
                        end else begin
                            state <= S_ERROR;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        checksum <= checksum ^ byte_data;
                        byte_idx <= byte_idx + 2'd1;
                        unique case (byte_idx)
                            2'd0: word_buf[7:0]   <= byte_data;
                            2'd1: word_buf[15:8]  <= byte_data;
                            2'd2: word_buf[23:16] <= byte_data;
                            2'd3: begin
                                mem_we    <= 1'b1;
                                mem_addr  <= word_idx[ADDR_W-1:0];
                                mem_wdata <= {byte_data, word_buf};
                                word_idx  <= word_idx + WIDX_ONE;
                                if (last_word) state <= S_CHECK;
                            end
                        endcase
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        if (byte_data == checksum) state <= S_DONE;
                        else                       state <= S_ERROR;
                    end
                end
                S_DONE, S_ERROR: begin
                    if (start) state <= S_COUNT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
